fp32_dot_sequencer: RTL and testbench
=====================================

# fp32_dot_sequencer

Controller that sequences a single shared FP32 multiply-accumulate unit to compute a dot product of LEN_I operand pairs. Operand pairs arrive on a valid/ready stream. The block issues each pair to the MAC together with the running accumulator, waits for the MAC result, and writes that result back as the new accumulator. After the last pair it presents the final sum on a result handshake. It sits between the operand source (RX/buffer side) and the MAC, and owns the accumulator register so the MAC stays stateless.

## Interface
- TIMEOUT, 1024: maximum cycles spent in WAIT for one MAC result before aborting with error.
- CLK_I  in  1  clock.
- RSTL_I  in  1  reset, asynchronous, active-low.
- START_I  in  1  start a dot product; sampled only in IDLE.
- LEN_I  in  16  number of pairs; sampled with START_I.
- ABORT_I  in  1  synchronous abort; forces IDLE from any state.
- BUSY_O  out  1  high in every state except IDLE.
- IN_VALID_I / IN_READY_O  in/out  1/1  operand stream handshake.
- IN_ALPHA_I, IN_BRAVO_I  in  32  FP32 operands.
- MAC_ALPHA_O, MAC_BRAVO_O, MAC_ACC_O  out  32  operands and accumulator presented to MAC.
- MAC_VALID_O / MAC_READY_I  out/in  1/1  issue handshake to MAC.
- MAC_VALID_I / MAC_READY_O  in/out  1/1  result handshake from MAC.
- MAC_DELTA_I  in  32  MAC result (alpha*bravo+acc).
- RES_VALID_O / RES_READY_I  out/in  1/1  final result handshake.
- RES_DATA_O  out  32  final accumulator.
- RES_ERR_O  out  1  result invalid (MAC timeout); valid with RES_VALID_O.

## Operation
- States: IDLE, FETCH, ISSUE, WAIT, DONE.
- IDLE:
  - START_I=1 latches LEN_I into len, clears acc to 32'h0000_0000 and cnt to 0, and clears the error flag.
  - Next state is FETCH, or DONE if LEN_I==0 (result +0.0).
- FETCH:
  - IN_READY_O=1.
  - On IN_VALID_I&IN_READY_O, latch alpha/bravo, go to ISSUE.
- ISSUE:
  - MAC_VALID_O=1. MAC_ALPHA_O/MAC_BRAVO_O/MAC_ACC_O hold the latched alpha/bravo/acc, stable until accepted.
  - On MAC_READY_I, go to WAIT and clear the timeout counter.
- WAIT:
  - MAC_READY_O=1.
  - On MAC_VALID_I, set acc ← MAC_DELTA_I and cnt ← cnt+1. Go to DONE if cnt+1==len, else FETCH.
  - The timeout counter increments each WAIT cycle. If it reaches TIMEOUT-1 without MAC_VALID_I, set the error flag and go to DONE.
- DONE:
  - RES_VALID_O=1, RES_DATA_O=acc, RES_ERR_O=error flag. All three are held stable until RES_READY_I.
  - On RES_READY_I, go to IDLE.
- Only one MAC operation is in flight at a time, because each issue depends on the previous result.
- The block does no arithmetic on FP data. acc is written only from MAC_DELTA_I, or cleared.
- cnt and len are 16 bits. len=65535 is legal; there is no wrap, because termination is on equality.
- ABORT_I has priority over every transition. It returns to IDLE, clears acc/cnt/error, and deasserts all valid/ready outputs the next cycle. Any in-flight MAC result arriving later is ignored (MAC_READY_O=0 in IDLE).
- START_I outside IDLE is ignored. IN_VALID_I outside FETCH is ignored. MAC_VALID_I outside WAIT is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, acc/cnt/len/error 0.
- All handshake outputs are decoded from the registered state only. There is no combinational path from any input to any output.
- A transfer occurs at the rising edge where valid&ready are both 1.
- START_I to IN_READY_O=1: 1 cycle.
- Minimum per pair is 3 cycles: FETCH 1, ISSUE 1, WAIT 1, assuming zero-wait source and MAC.
- Minimum total, START_I to RES_VALID_O: 1+3·LEN cycles. For LEN=0 it is 1 cycle.
- MAC_ACC_O equals the result of the previous pair (0 for the first pair).
- In WAIT, a MAC_VALID_I arriving in the same cycle as the timeout expiry wins: the result is accepted and there is no error.

## Test plan
- Single pair: LEN=1, (32'hBF00_0000, 32'h3F40_0000), MAC model with 1-cycle latency.
  - Required: RES_DATA_O=32'hBEC0_0000 (-0.375), RES_ERR_O=0, RES_VALID_O 4 cycles after START_I.
- Three pairs: (3F80_0000, 4000_0000), (3F00_0000, 4080_0000), (BF80_0000, 3F80_0000).
  - Required: MAC_ACC_O sequence 0, 4000_0000, 4080_0000.
  - Required: RES_DATA_O=32'h4040_0000 (3.0).
- Backpressure with the three-pair vector:
  - Stimulus: random IN_VALID_I gaps, MAC_READY_I low for 5 cycles, MAC latency 7, RES_READY_I low for 10 cycles.
  - Required: same 32'h4040_0000, MAC_* operands stable while MAC_VALID_O&!MAC_READY_I, RES_DATA_O stable while stalled.
- LEN=0:
  - Required: RES_VALID_O=1, RES_DATA_O=0, RES_ERR_O=0 one cycle after START_I; IN_READY_O never asserted.
- Timeout: TIMEOUT=16, MAC never returns MAC_VALID_I.
  - Required: DONE with RES_ERR_O=1 after 16 WAIT cycles.
  - Then a fresh START_I with LEN=1 completes with RES_ERR_O=0.
- Abort: ABORT_I during WAIT of pair 2 of 3, then a late MAC_VALID_I.
  - Required: IDLE next cycle, BUSY_O=0, no RES_VALID_O, MAC_READY_O=0.
  - Required: a new run gives the correct result from acc=0.
  - Separately, RSTL_I asserted mid-run clears all outputs immediately.

Source files
------------

// File: rtl/fp32_dot_sequencer.sv
// Sequences one shared, stateless FP32 MAC through a dot product of LEN_I operand pairs.
// Owns the accumulator; every handshake output is a registered flag.
module fp32_dot_sequencer #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        CLK_I,
    input  logic        RSTL_I,
    input  logic        START_I,
    input  logic [15:0] LEN_I,
    input  logic        ABORT_I,
    output logic        BUSY_O,
    input  logic        IN_VALID_I,
    output logic        IN_READY_O,
    input  logic [31:0] IN_ALPHA_I,
    input  logic [31:0] IN_BRAVO_I,
    output logic [31:0] MAC_ALPHA_O,
    output logic [31:0] MAC_BRAVO_O,
    output logic [31:0] MAC_ACC_O,
    output logic        MAC_VALID_O,
    input  logic        MAC_READY_I,
    input  logic        MAC_VALID_I,
    output logic        MAC_READY_O,
    input  logic [31:0] MAC_DELTA_I,
    output logic        RES_VALID_O,
    input  logic        RES_READY_I,
    output logic [31:0] RES_DATA_O,
    output logic        RES_ERR_O
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StFetch, StIssue, StWait, StDone} state_t;

    state_t        state;
    logic [15:0]   len;
    logic [15:0]   cnt;
    logic [15:0]   cnt_inc;
    logic [31:0]   alpha;
    logic [31:0]   bravo;
    logic [31:0]   acc;
    logic          err;
    logic [TW-1:0] tcnt;
    logic          busy;
    logic          in_ready;
    logic          mac_valid;
    logic          mac_ready;
    logic          res_valid;

    assign cnt_inc = cnt + 16'd1;

    always_ff @(posedge CLK_I or negedge RSTL_I) begin
        if (!RSTL_I) begin
            state     <= StIdle;
            len       <= '0;
            cnt       <= '0;
            alpha     <= '0;
            bravo     <= '0;
            acc       <= '0;
            err       <= 1'b0;
            tcnt      <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            mac_valid <= 1'b0;
            mac_ready <= 1'b0;
            res_valid <= 1'b0;
        end else if (ABORT_I) begin
            state     <= StIdle;
            cnt       <= '0;
            acc       <= '0;
            err       <= 1'b0;
            tcnt      <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            mac_valid <= 1'b0;
            mac_ready <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (START_I) begin
                        len  <= LEN_I;
                        cnt  <= '0;
                        acc  <= '0;
                        err  <= 1'b0;
                        busy <= 1'b1;
                        if (LEN_I == 16'd0) begin
                            state     <= StDone;
                            res_valid <= 1'b1;
                        end else begin
                            state    <= StFetch;
                            in_ready <= 1'b1;
                        end
                    end
                end
                StFetch: begin
                    if (IN_VALID_I) begin
                        alpha     <= IN_ALPHA_I;
                        bravo     <= IN_BRAVO_I;
                        state     <= StIssue;
                        in_ready  <= 1'b0;
                        mac_valid <= 1'b1;
                    end
                end
                StIssue: begin
                    if (MAC_READY_I) begin
                        state     <= StWait;
                        tcnt      <= '0;
                        mac_valid <= 1'b0;
                        mac_ready <= 1'b1;
                    end
                end
                StWait: begin
                    // A result arriving on the expiry cycle still wins over the timeout.
                    if (MAC_VALID_I) begin
                        acc       <= MAC_DELTA_I;
                        cnt       <= cnt_inc;
                        mac_ready <= 1'b0;
                        if (cnt_inc == len) begin
                            state     <= StDone;
                            res_valid <= 1'b1;
                        end else begin
                            state    <= StFetch;
                            in_ready <= 1'b1;
                        end
                    end else if (tcnt == TLAST) begin
                        err       <= 1'b1;
                        mac_ready <= 1'b0;
                        state     <= StDone;
                        res_valid <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                StDone: begin
                    if (RES_READY_I) begin
                        state     <= StIdle;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= StIdle;
                    busy      <= 1'b0;
                    in_ready  <= 1'b0;
                    mac_valid <= 1'b0;
                    mac_ready <= 1'b0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY_O      = busy;
    assign IN_READY_O  = in_ready;
    assign MAC_VALID_O = mac_valid;
    assign MAC_READY_O = mac_ready;
    assign RES_VALID_O = res_valid;
    assign MAC_ALPHA_O = alpha;
    assign MAC_BRAVO_O = bravo;
    assign MAC_ACC_O   = acc;
    assign RES_DATA_O  = acc;
    assign RES_ERR_O   = err;

endmodule

// File: tb/tb_fp32_dot_sequencer.sv
// Directed bench for fp32_dot_sequencer: a table-driven MAC model returns hand-computed
// FP32 results and checks the operands it is handed.
module tb_fp32_dot_sequencer;

    logic        CLK_I = 1'b0;
    logic        RSTL_I;
    logic        START_I = 1'b0;
    logic [15:0] LEN_I = '0;
    logic        ABORT_I = 1'b0;
    logic        BUSY_O;
    logic        IN_VALID_I = 1'b0;
    logic        IN_READY_O;
    logic [31:0] IN_ALPHA_I = '0;
    logic [31:0] IN_BRAVO_I = '0;
    logic [31:0] MAC_ALPHA_O, MAC_BRAVO_O, MAC_ACC_O;
    logic        MAC_VALID_O;
    logic        MAC_READY_I = 1'b0;
    logic        MAC_VALID_I = 1'b0;
    logic        MAC_READY_O;
    logic [31:0] MAC_DELTA_I = '0;
    logic        RES_VALID_O;
    logic        RES_READY_I = 1'b0;
    logic [31:0] RES_DATA_O;
    logic        RES_ERR_O;

    fp32_dot_sequencer #(.TIMEOUT(16)) dut (
        .CLK_I(CLK_I), .RSTL_I(RSTL_I), .START_I(START_I), .LEN_I(LEN_I), .ABORT_I(ABORT_I),
        .BUSY_O(BUSY_O), .IN_VALID_I(IN_VALID_I), .IN_READY_O(IN_READY_O),
        .IN_ALPHA_I(IN_ALPHA_I), .IN_BRAVO_I(IN_BRAVO_I), .MAC_ALPHA_O(MAC_ALPHA_O),
        .MAC_BRAVO_O(MAC_BRAVO_O), .MAC_ACC_O(MAC_ACC_O), .MAC_VALID_O(MAC_VALID_O),
        .MAC_READY_I(MAC_READY_I), .MAC_VALID_I(MAC_VALID_I), .MAC_READY_O(MAC_READY_O),
        .MAC_DELTA_I(MAC_DELTA_I), .RES_VALID_O(RES_VALID_O), .RES_READY_I(RES_READY_I),
        .RES_DATA_O(RES_DATA_O), .RES_ERR_O(RES_ERR_O)
    );

    always #5 CLK_I = ~CLK_I;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Vector table: operands, expected accumulator at issue, MAC result.
    logic [31:0] va[3], vb[3], vacc[3], vd[3];
    logic [31:0] acc_seen[3];
    int          res_cycle, op_bad, res_bad, mac_rdy_cycles;
    logic [31:0] res_data;
    logic        res_err, saw_in_ready, abort_hit;

    function automatic logic [133:0] outs();
        return {BUSY_O, IN_READY_O, MAC_VALID_O, MAC_READY_O, RES_VALID_O, RES_ERR_O,
                MAC_ALPHA_O, MAC_BRAVO_O, MAC_ACC_O, RES_DATA_O};
    endfunction

    task automatic load_single();
        va[0] = 32'hBF00_0000; vb[0] = 32'h3F40_0000; vacc[0] = 32'h0; vd[0] = 32'hBEC0_0000;
    endtask

    task automatic load_three();
        va[0] = 32'h3F80_0000; vb[0] = 32'h4000_0000; vacc[0] = 32'h0; vd[0] = 32'h4000_0000;
        va[1] = 32'h3F00_0000; vb[1] = 32'h4080_0000; vacc[1] = 32'h4000_0000;
        vd[1] = 32'h4080_0000;
        va[2] = 32'hBF80_0000; vb[2] = 32'h3F80_0000; vacc[2] = 32'h4080_0000;
        vd[2] = 32'h4040_0000;
    endtask

    // Drives one job cycle by cycle at the falling edge; c counts rising edges since START.
    task automatic run_job(input int len, input int n, input bit gaps, input int rdy_hold,
                           input int lat, input int res_hold, input bit never,
                           input int abort_pair);
        int c, src_idx, mac_idx, rsp_idx, issue_wait, lat_cnt, res_wait;
        bit pending, done;
        src_idx = 0; mac_idx = 0; rsp_idx = 0; issue_wait = 0; lat_cnt = 0; res_wait = 0;
        pending = 0; done = 0;
        res_cycle = -1; op_bad = 0; res_bad = 0; mac_rdy_cycles = 0;
        res_data = '0; res_err = 1'b0; saw_in_ready = 1'b0; abort_hit = 1'b0;
        @(negedge CLK_I);
        START_I = 1'b1; LEN_I = len[15:0];
        @(negedge CLK_I);
        START_I = 1'b0;
        c = 1;
        while (!done && c < 400) begin
            if (IN_READY_O) saw_in_ready = 1'b1;
            if (MAC_READY_O) mac_rdy_cycles++;
            IN_VALID_I = (src_idx < n) && (!gaps || $urandom_range(0, 2) != 0);
            if (src_idx < n) begin
                IN_ALPHA_I = va[src_idx]; IN_BRAVO_I = vb[src_idx];
            end
            if (IN_VALID_I && IN_READY_O) src_idx++;
            MAC_VALID_I = 1'b0;
            if (pending) begin
                lat_cnt++;
                if (abort_pair == rsp_idx && MAC_READY_O) begin
                    ABORT_I = 1'b1; abort_hit = 1'b1;
                end else if (lat_cnt >= lat && !never) begin
                    MAC_VALID_I = 1'b1; MAC_DELTA_I = vd[rsp_idx];
                    if (MAC_READY_O) begin
                        pending = 0; rsp_idx++;
                    end
                end
            end
            MAC_READY_I = 1'b0;
            if (MAC_VALID_O) begin
                if (mac_idx >= n || MAC_ALPHA_O !== va[mac_idx] || MAC_BRAVO_O !== vb[mac_idx]
                    || MAC_ACC_O !== vacc[mac_idx]) op_bad++;
                if (issue_wait >= rdy_hold) begin
                    MAC_READY_I = 1'b1;
                    if (mac_idx < n) acc_seen[mac_idx] = MAC_ACC_O;
                    mac_idx++; pending = 1; lat_cnt = 0; issue_wait = 0;
                end else begin
                    issue_wait++;
                end
            end
            RES_READY_I = 1'b0;
            if (RES_VALID_O) begin
                if (res_cycle < 0) begin
                    res_cycle = c; res_data = RES_DATA_O; res_err = RES_ERR_O;
                end else if (RES_DATA_O !== res_data || RES_ERR_O !== res_err) begin
                    res_bad++;
                end
                RES_READY_I = (res_wait >= res_hold);
                res_wait++;
            end
            if ((RES_VALID_O && RES_READY_I) || abort_hit) done = 1;
            @(negedge CLK_I);
            c++;
        end
        IN_VALID_I = 1'b0; MAC_READY_I = 1'b0; MAC_VALID_I = 1'b0; RES_READY_I = 1'b0;
        ABORT_I = 1'b0;
        if (!done) begin
            total_cnt++;
            $display("FAIL job_bound: job len=%0d not finished, cycles=%0d required <400", len, c);
        end
    endtask

    task automatic test_reset();
        RSTL_I = 1'b0;
        #1;
        total_cnt++;
        if (outs() !== '0) $display("FAIL reset_outs: got %h required 0", outs());
        else pass_cnt++;
        @(negedge CLK_I);
        RSTL_I = 1'b1;
    endtask

    task automatic test_single();
        load_single();
        run_job(1, 1, 0, 0, 1, 0, 0, -1);
        total_cnt++;
        if (res_data !== 32'hBEC0_0000) $display("FAIL single_data: got %h required BEC00000", res_data);
        else pass_cnt++;
        total_cnt++;
        if (res_err !== 1'b0) $display("FAIL single_err: got %b required 0", res_err);
        else pass_cnt++;
        total_cnt++;
        if (res_cycle !== 4) $display("FAIL single_latency: got %0d required 4", res_cycle);
        else pass_cnt++;
        total_cnt++;
        if (op_bad !== 0) $display("FAIL single_operands: bad cycles %0d required 0", op_bad);
        else pass_cnt++;
    endtask

    task automatic test_three();
        load_three();
        run_job(3, 3, 0, 0, 1, 0, 0, -1);
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (acc_seen[i] !== vacc[i])
                $display("FAIL three_acc%0d: got %h required %h", i, acc_seen[i], vacc[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (res_data !== 32'h4040_0000) $display("FAIL three_data: got %h required 40400000", res_data);
        else pass_cnt++;
        total_cnt++;
        if (res_err !== 1'b0) $display("FAIL three_err: got %b required 0", res_err);
        else pass_cnt++;
        total_cnt++;
        if (res_cycle !== 10) $display("FAIL three_latency: got %0d required 10", res_cycle);
        else pass_cnt++;
        total_cnt++;
        if (op_bad !== 0) $display("FAIL three_operands: bad cycles %0d required 0", op_bad);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        load_three();
        run_job(3, 3, 1, 5, 7, 10, 0, -1);
        total_cnt++;
        if (res_data !== 32'h4040_0000) $display("FAIL bp_data: got %h required 40400000", res_data);
        else pass_cnt++;
        total_cnt++;
        if (res_err !== 1'b0) $display("FAIL bp_err: got %b required 0", res_err);
        else pass_cnt++;
        total_cnt++;
        if (op_bad !== 0) $display("FAIL bp_operands_stable: bad cycles %0d required 0", op_bad);
        else pass_cnt++;
        total_cnt++;
        if (res_bad !== 0) $display("FAIL bp_result_stable: bad cycles %0d required 0", res_bad);
        else pass_cnt++;
    endtask

    task automatic test_len_zero();
        run_job(0, 0, 0, 0, 1, 0, 0, -1);
        total_cnt++;
        if (res_cycle !== 1) $display("FAIL len0_latency: got %0d required 1", res_cycle);
        else pass_cnt++;
        total_cnt++;
        if (res_data !== 32'h0) $display("FAIL len0_data: got %h required 0", res_data);
        else pass_cnt++;
        total_cnt++;
        if (res_err !== 1'b0) $display("FAIL len0_err: got %b required 0", res_err);
        else pass_cnt++;
        total_cnt++;
        if (saw_in_ready !== 1'b0) $display("FAIL len0_in_ready: got %b required 0", saw_in_ready);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        load_single();
        run_job(1, 1, 0, 0, 1, 0, 1, -1);
        // FETCH at 1, ISSUE at 2, WAIT 3..18, DONE at 19.
        total_cnt++;
        if (res_cycle !== 19) $display("FAIL to_latency: got %0d required 19", res_cycle);
        else pass_cnt++;
        total_cnt++;
        if (res_err !== 1'b1) $display("FAIL to_err: got %b required 1", res_err);
        else pass_cnt++;
        total_cnt++;
        if (mac_rdy_cycles !== 16) $display("FAIL to_wait_cycles: got %0d required 16", mac_rdy_cycles);
        else pass_cnt++;
        run_job(1, 1, 0, 0, 1, 0, 0, -1);
        total_cnt++;
        if (res_err !== 1'b0) $display("FAIL to_rerun_err: got %b required 0", res_err);
        else pass_cnt++;
        total_cnt++;
        if (res_data !== 32'hBEC0_0000) $display("FAIL to_rerun_data: got %h required BEC00000", res_data);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        load_three();
        run_job(3, 3, 0, 0, 3, 0, 0, 1);
        total_cnt++;
        if (abort_hit !== 1'b1) $display("FAIL abort_reached: got %b required 1", abort_hit);
        else pass_cnt++;
        total_cnt++;
        if ({BUSY_O, RES_VALID_O, MAC_READY_O, IN_READY_O, MAC_VALID_O} !== 5'b0)
            $display("FAIL abort_idle: busy/res_v/mac_r/in_r/mac_v got %b required 00000",
                     {BUSY_O, RES_VALID_O, MAC_READY_O, IN_READY_O, MAC_VALID_O});
        else pass_cnt++;
        MAC_VALID_I = 1'b1; MAC_DELTA_I = 32'h4080_0000;
        @(negedge CLK_I);
        @(negedge CLK_I);
        MAC_VALID_I = 1'b0;
        total_cnt++;
        if ({BUSY_O, RES_VALID_O, MAC_READY_O} !== 3'b0)
            $display("FAIL abort_late_idle: busy/res_v/mac_r got %b required 000",
                     {BUSY_O, RES_VALID_O, MAC_READY_O});
        else pass_cnt++;
        total_cnt++;
        if (RES_DATA_O !== 32'h0) $display("FAIL abort_late_acc: got %h required 0", RES_DATA_O);
        else pass_cnt++;
        run_job(3, 3, 0, 0, 1, 0, 0, -1);
        total_cnt++;
        if (res_data !== 32'h4040_0000) $display("FAIL abort_rerun_data: got %h required 40400000", res_data);
        else pass_cnt++;
        total_cnt++;
        if (op_bad !== 0) $display("FAIL abort_rerun_operands: bad cycles %0d required 0", op_bad);
        else pass_cnt++;
    endtask

    task automatic test_reset_midrun();
        load_three();
        @(negedge CLK_I);
        START_I = 1'b1; LEN_I = 16'd3;
        @(negedge CLK_I);
        START_I = 1'b0;
        IN_VALID_I = 1'b1; IN_ALPHA_I = va[0]; IN_BRAVO_I = vb[0];
        @(negedge CLK_I);
        IN_VALID_I = 1'b0;
        total_cnt++;
        if ({MAC_VALID_O, MAC_ALPHA_O} !== {1'b1, va[0]})
            $display("FAIL midrst_pre: mac_v/alpha got %b/%h required 1/%h",
                     MAC_VALID_O, MAC_ALPHA_O, va[0]);
        else pass_cnt++;
        #2;
        RSTL_I = 1'b0;
        #1;
        total_cnt++;
        if (outs() !== '0) $display("FAIL midrst_outs: got %h required 0", outs());
        else pass_cnt++;
        @(negedge CLK_I);
        RSTL_I = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_three();
        test_backpressure();
        test_len_zero();
        test_timeout();
        test_abort();
        test_reset_midrun();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
